// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file, immediate extender and an ID/EX output register
// with a valid/ready handshake, flush, write-to-read bypass and operand refresh
// for an entry that is stalled.
module decode_stage_pipelined #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       instr,
    input  logic [XLEN-1:0]       pc4,
    input  logic                  ctl_a1_zero,
    input  logic [2:0]            ctl_ext,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [XLEN-1:0]       wb_link,
    input  logic                  wb_sel_link,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_r1,
    output logic [XLEN-1:0]       out_r2,
    output logic [XLEN-1:0]       out_imm,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_pc4
);

    localparam int unsigned numRegs = 1 << REG_ADDR_W;

    // Immediate format encodings on ctl_ext
    localparam logic [2:0] extI = 3'd0;
    localparam logic [2:0] extS = 3'd1;
    localparam logic [2:0] extB = 3'd2;
    localparam logic [2:0] extU = 3'd3;
    localparam logic [2:0] extJ = 3'd4;

    logic [XLEN-1:0]       regFile [numRegs];

    logic [REG_ADDR_W-1:0] rs1Dec;
    logic [REG_ADDR_W-1:0] rs2Dec;
    logic [REG_ADDR_W-1:0] rdDec;
    logic [31:0]           imm32;
    logic [XLEN-1:0]       immDec;

    logic [XLEN-1:0]       wbValue;
    logic                  wbHit;
    logic [XLEN-1:0]       rd1Old;
    logic [XLEN-1:0]       rd2Old;
    logic [XLEN-1:0]       rd1Val;
    logic [XLEN-1:0]       rd2Val;

    logic                  capture;
    logic [REG_ADDR_W-1:0] heldRs1;
    logic [REG_ADDR_W-1:0] heldRs2;

    // Register field extraction, resized to the configured address width
    assign rs1Dec = ctl_a1_zero ? '0 : REG_ADDR_W'(instr[19:15]);
    assign rs2Dec = REG_ADDR_W'(instr[24:20]);
    assign rdDec  = REG_ADDR_W'(instr[11:7]);

    // Immediate assembly in 32 bits; formats 5..7 produce zero
    always_comb begin
        imm32 = '0;
        case (ctl_ext)
            extI:    imm32 = {{20{instr[31]}}, instr[31:20]};
            extS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            extB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            extU:    imm32 = {instr[31:12], 12'b0};
            extJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Sign-extend the assembled immediate to the datapath width
    assign immDec = XLEN'($signed(imm32));

    // Write-back value and whether it lands in a real register
    assign wbValue = wb_sel_link ? wb_link : wb_data;
    assign wbHit   = wb_en && (wb_addr != '0);

    // Combinational reads with optional same-cycle forwarding of the write
    always_comb begin
        rd1Old = (rs1Dec == '0) ? '0 : regFile[rs1Dec];
        rd2Old = (rs2Dec == '0) ? '0 : regFile[rs2Dec];
        rd1Val = rd1Old;
        rd2Val = rd2Old;
        if (BYPASS && wbHit && (wb_addr == rs1Dec)) begin
            rd1Val = wbValue;
        end
        if (BYPASS && wbHit && (wb_addr == rs2Dec)) begin
            rd2Val = wbValue;
        end
    end

    // Register file storage; writes ignore handshake, stall and flush
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < numRegs; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbHit) begin
            regFile[wb_addr] <= wbValue;
        end
    end

    // Stage accepts whenever the output slot is empty or draining
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // ID/EX register: reset, flush, capture, drain, or hold with operand refresh
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_r1    <= '0;
            out_r2    <= '0;
            out_imm   <= '0;
            out_rd    <= '0;
            out_pc4   <= '0;
            heldRs1   <= '0;
            heldRs2   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_r1    <= rd1Val;
            out_r2    <= rd2Val;
            out_imm   <= immDec;
            out_rd    <= rdDec;
            out_pc4   <= pc4;
            heldRs1   <= rs1Dec;
            heldRs2   <= rs2Dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (wbHit && (wb_addr == heldRs1)) begin
                out_r1 <= wbValue;
            end
            if (wbHit && (wb_addr == heldRs2)) begin
                out_r2 <= wbValue;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed steps then random traffic, both
// BYPASS variants driven in parallel and compared to a behavioural model.
module tb_decode_stage_pipelined;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        a1z;
    logic [2:0]  ext;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic [31:0] wbLink;
    logic        wbSel;
    logic        flush;
    logic        outReady;

    logic        bInReady, bOutValid, nInReady, nOutValid;
    logic [31:0] bR1, bR2, bImm, bPc4, nR1, nR2, nImm, nPc4;
    logic [4:0]  bRd, nRd;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic        mValid;
    logic [31:0] mR1B, mR1N, mR2B, mR2N, mImm, mPc4;
    logic [4:0]  mRd, mRs1, mRs2;
    logic [31:0] mRegs [32];

    always #5 clock = ~clock;

    decode_stage_pipelined #(.XLEN(32), .REG_ADDR_W(5), .BYPASS(1'b1)) dutByp (
        .clock(clock), .reset(reset), .in_valid(inValid), .in_ready(bInReady),
        .instr(instr), .pc4(pc4), .ctl_a1_zero(a1z), .ctl_ext(ext),
        .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData), .wb_link(wbLink),
        .wb_sel_link(wbSel), .flush(flush), .out_valid(bOutValid),
        .out_ready(outReady), .out_r1(bR1), .out_r2(bR2), .out_imm(bImm),
        .out_rd(bRd), .out_pc4(bPc4)
    );

    decode_stage_pipelined #(.XLEN(32), .REG_ADDR_W(5), .BYPASS(1'b0)) dutNoByp (
        .clock(clock), .reset(reset), .in_valid(inValid), .in_ready(nInReady),
        .instr(instr), .pc4(pc4), .ctl_a1_zero(a1z), .ctl_ext(ext),
        .wb_en(wbEn), .wb_addr(wbAddr), .wb_data(wbData), .wb_link(wbLink),
        .wb_sel_link(wbSel), .flush(flush), .out_valid(nOutValid),
        .out_ready(outReady), .out_r1(nR1), .out_r2(nR2), .out_imm(nImm),
        .out_rd(nRd), .out_pc4(nPc4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Immediate value straight from the format table
    function automatic logic [31:0] immOf(input logic [31:0] i, input logic [2:0] e);
        case (e)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] readReg(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : mRegs[a];
    endfunction

    task automatic modelReset();
        mValid = 1'b0;
        mR1B = '0; mR1N = '0; mR2B = '0; mR2N = '0;
        mImm = '0; mPc4 = '0; mRd = '0; mRs1 = '0; mRs2 = '0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
    endtask

    task automatic idle();
        reset = 0; inValid = 0; a1z = 0; ext = 3'd0; wbEn = 0; wbAddr = '0;
        wbData = '0; wbLink = '0; wbSel = 0; flush = 0; outReady = 1;
    endtask

    // One clock: check in_ready, advance the model, check outputs after the edge
    task automatic step();
        logic [31:0] wv;
        logic        hit, rdy, cap;
        logic [4:0]  s1, s2;
        #1;
        rdy = !mValid || outReady;
        chk("in_ready_byp", 64'(bInReady), 64'(rdy));
        chk("in_ready_nobyp", 64'(nInReady), 64'(rdy));
        wv  = wbSel ? wbLink : wbData;
        hit = wbEn && (wbAddr != 5'd0);
        cap = inValid && rdy && !flush;
        if (reset) begin
            modelReset();
        end else begin
            if (flush) begin
                mValid = 1'b0;
            end else if (cap) begin
                s1 = a1z ? 5'd0 : instr[19:15];
                s2 = instr[24:20];
                mR1N = readReg(s1);
                mR2N = readReg(s2);
                mR1B = (hit && wbAddr == s1) ? wv : mR1N;
                mR2B = (hit && wbAddr == s2) ? wv : mR2N;
                mImm = immOf(instr, ext);
                mRd = instr[11:7];
                mPc4 = pc4;
                mRs1 = s1;
                mRs2 = s2;
                mValid = 1'b1;
            end else if (outReady) begin
                mValid = 1'b0;
            end else if (mValid) begin
                if (hit && wbAddr == mRs1) begin mR1B = wv; mR1N = wv; end
                if (hit && wbAddr == mRs2) begin mR2B = wv; mR2N = wv; end
            end
            if (hit) mRegs[wbAddr] = wv;
        end
        @(posedge clock);
        #1;
        chk("out_valid_byp", 64'(bOutValid), 64'(mValid));
        chk("out_valid_nobyp", 64'(nOutValid), 64'(mValid));
        if (mValid) begin
            chk("r1_byp", 64'(bR1), 64'(mR1B));
            chk("r1_nobyp", 64'(nR1), 64'(mR1N));
            chk("r2_byp", 64'(bR2), 64'(mR2B));
            chk("r2_nobyp", 64'(nR2), 64'(mR2N));
            chk("imm", 64'(bImm), 64'(mImm));
            chk("imm_nobyp", 64'(nImm), 64'(mImm));
            chk("rd", 64'(bRd), 64'(mRd));
            chk("pc4", 64'(bPc4), 64'(mPc4));
        end
    endtask

    initial begin
        logic [4:0] ri;
        idle();
        instr = '0;
        pc4 = '0;

        // Initial reset
        reset = 1;
        @(posedge clock);
        #1;
        modelReset();
        reset = 0;
        chk("rst_valid", 64'(bOutValid), 64'd0);
        chk("rst_in_ready", 64'(bInReady), 64'd1);
        chk("rst_r1", 64'(bR1), 64'd0);
        chk("rst_imm", 64'(bImm), 64'd0);
        chk("rst_pc4", 64'(nPc4), 64'd0);

        // x5 = 0xAA, then addi x1,x5,0
        wbEn = 1; wbAddr = 5'd5; wbData = 32'hAA;
        step();
        idle();
        inValid = 1; instr = 32'h0002_8093; pc4 = 32'h104;
        step();
        chk("addi_valid", 64'(bOutValid), 64'd1);
        chk("addi_r1", 64'(bR1), 64'hAA);
        chk("addi_imm", 64'(bImm), 64'd0);
        chk("addi_rd", 64'(bRd), 64'd1);

        // Same-cycle write and capture of rs1=5
        wbEn = 1; wbAddr = 5'd5; wbData = 32'h1234;
        step();
        chk("bypass_on_r1", 64'(bR1), 64'h1234);
        chk("bypass_off_r1", 64'(nR1), 64'hAA);

        // Capture rs2=6, stall three cycles, write x6 mid-stall
        idle();
        inValid = 1; instr = 32'h0060_01B3; pc4 = 32'h200;
        step();
        outReady = 0; instr = 32'h0000_0013;
        step();
        chk("stall_in_ready", 64'(bInReady), 64'd0);
        wbEn = 1; wbAddr = 5'd6; wbData = 32'hBEEF;
        step();
        chk("stall_refresh_r2", 64'(bR2), 64'hBEEF);
        chk("stall_refresh_r2_nobyp", 64'(nR2), 64'hBEEF);
        wbEn = 0;
        step();
        chk("stall_held_valid", 64'(bOutValid), 64'd1);
        chk("stall_in_ready_late", 64'(nInReady), 64'd0);
        outReady = 1; inValid = 0;
        step();
        chk("release_valid", 64'(bOutValid), 64'd0);

        // Immediate sweep; write to x0 must be ignored
        idle();
        inValid = 1; instr = 32'hFE00_0FE3; ext = 3'd2;
        wbEn = 1; wbAddr = 5'd0; wbData = 32'hFFFF;
        step();
        chk("imm_b", 64'(bImm), 64'hFFFF_FFFE);
        wbEn = 0; ext = 3'd3;
        step();
        chk("imm_u", 64'(bImm), 64'hFE00_0000);
        chk("x0_reads_zero", 64'(bR1), 64'd0);
        ext = 3'd6;
        step();
        chk("imm_reserved", 64'(bImm), 64'd0);

        // Link select write, then read x1 with and without a1 forced to zero
        idle();
        wbEn = 1; wbAddr = 5'd1; wbSel = 1; wbLink = 32'h104; wbData = 32'h9;
        step();
        idle();
        inValid = 1; instr = 32'h0000_8113;
        step();
        chk("link_write_r1", 64'(bR1), 64'h104);
        a1z = 1;
        step();
        chk("a1_zero_r1", 64'(bR1), 64'd0);

        // Flush against a held entry with a new instruction offered
        idle();
        inValid = 1; instr = 32'h0060_01B3;
        step();
        outReady = 0; inValid = 0;
        step();
        flush = 1; inValid = 1;
        step();
        chk("flush_valid", 64'(bOutValid), 64'd0);
        chk("flush_valid_nobyp", 64'(nOutValid), 64'd0);

        // Reset in the middle of a stall, then every register reads zero
        idle();
        inValid = 1; instr = 32'h0002_8093;
        step();
        outReady = 0; inValid = 0;
        step();
        reset = 1;
        step();
        chk("midstall_rst_valid", 64'(bOutValid), 64'd0);
        idle();
        for (int i = 0; i < 32; i++) begin
            ri = 5'(i);
            inValid = 1;
            instr = {7'b0, ri, ri, 3'b000, 5'd1, 7'h33};
            step();
            chk("post_rst_r1", 64'(bR1), 64'd0);
            chk("post_rst_r2", 64'(nR2), 64'd0);
        end

        // Random traffic with small register indices to force collisions
        idle();
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            inValid  = ($urandom_range(0, 9) < 7);
            instr    = $urandom;
            instr[19:15] = 5'($urandom_range(0, 7));
            instr[24:20] = 5'($urandom_range(0, 7));
            pc4      = $urandom;
            a1z      = ($urandom_range(0, 7) == 0);
            ext      = 3'($urandom_range(0, 7));
            wbEn     = ($urandom_range(0, 1) == 1);
            wbAddr   = 5'($urandom_range(0, 7));
            wbData   = $urandom;
            wbLink   = $urandom;
            wbSel    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            outReady = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
